// File: rtl/sm_mem_pkg.sv
// Shared types and helpers for the data-side load/store path.
// Big-endian lanes: byte offset 0 lives in bits 31:24.
package sm_mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_STORE_W   = 3'd2,
    ST_RMW_READ  = 3'd3,
    ST_RMW_WRITE = 3'd4,
    ST_RESP      = 3'd5
  } lsu_state_t;

  // MSB of byte lane k within a big-endian word (31 - 8k).
  function automatic logic [4:0] lane_msb(input logic [1:0] k);
    return 5'd31 - {k, 3'b000};
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
// Halfwords only ever sit at offset 0 or 2, so bit 0 of the offset is ignored for them.
module byte_lane_unit
  import sm_mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  byte_msb;
  logic [4:0]  half_msb;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Select the addressed lane and extend it into a right-justified result.
  always_comb begin
    byte_msb = lane_msb(offset);
    half_msb = lane_msb({offset[1], 1'b0});
    byte_val = rd_word[byte_msb -: 8];
    half_val = rd_word[half_msb -: 16];
    load_data = 32'd0;
    case (size)
      MEM_BYTE: begin
        if (sign_ext) begin
          load_data = {{24{byte_val[7]}}, byte_val};
        end else begin
          load_data = {24'd0, byte_val};
        end
      end
      MEM_HALF: begin
        if (sign_ext) begin
          load_data = {{16{half_val[15]}}, half_val};
        end else begin
          load_data = {16'd0, half_val};
        end
      end
      MEM_WORD: load_data = rd_word;
      default:  load_data = 32'd0;
    endcase
  end

  // Replace the target lane of the read word with the store data.
  always_comb begin
    merge_data = rd_word;
    case (size)
      MEM_BYTE: merge_data[byte_msb -: 8]  = wdata[7:0];
      MEM_HALF: merge_data[half_msb -: 16] = wdata[15:0];
      default:  merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store engine toward a word-addressed data memory.
// Sub-word stores are read-modify-write; errors are answered without touching memory.
module load_store_unit
  import sm_mem_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_write_enable,
  output logic [31:0] mem_adress,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        error_q, error_d;

  logic        size_err;
  logic        range_err;
  logic        req_err;
  logic [31:0] lane_word;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Classify the incoming request: bad size, misalignment or out of range.
  always_comb begin
    size_err = 1'b0;
    case (req_size)
      MEM_BYTE: size_err = 1'b0;
      MEM_HALF: size_err = req_addr[0];
      MEM_WORD: size_err = |req_addr[1:0];
      default:  size_err = 1'b1;
    endcase
    range_err = (req_addr >= ADDR_LIMIT);
    req_err   = size_err | range_err;
  end

  // The lane unit sees live memory data for loads and the captured word for merges.
  assign lane_word = (state_q == ST_LOAD) ? mem_read_data : merge_q;

  byte_lane_unit u_lane (
    .rd_word    (lane_word),
    .offset     (addr_q[1:0]),
    .size       (size_q),
    .sign_ext   (signed_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    size_d   = size_q;
    signed_d = signed_q;
    error_d  = error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          size_d   = req_size;
          signed_d = req_signed;
          error_d  = req_err;
          rdata_d  = 32'd0;
          if (req_err) begin
            state_d = ST_RESP;
          end else if (!req_write) begin
            state_d = ST_LOAD;
          end else if (req_size == MEM_WORD) begin
            state_d = ST_STORE_W;
          end else begin
            state_d = ST_RMW_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        rdata_d = load_data;
        state_d = ST_RESP;
      end
      ST_STORE_W:   state_d = ST_RESP;
      ST_RMW_READ: begin
        merge_d = mem_read_data;
        state_d = ST_RMW_WRITE;
      end
      ST_RMW_WRITE: state_d = ST_RESP;
      ST_RESP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      merge_q  <= 32'd0;
      rdata_q  <= 32'd0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      error_q  <= error_d;
    end
  end

  // Port outputs decoded from the state register only, so reset clears them at once.
  always_comb begin
    req_ready        = (state_q == ST_IDLE);
    rsp_valid        = (state_q == ST_RESP);
    rsp_rdata        = rdata_q;
    rsp_error        = error_q;
    mem_adress       = {addr_q[31:2], 2'b00};
    mem_write_enable = 1'b0;
    mem_write_data   = 32'd0;
    case (state_q)
      ST_IDLE: mem_adress = 32'd0;
      ST_STORE_W: begin
        mem_write_enable = 1'b1;
        mem_write_data   = wdata_q;
      end
      ST_RMW_WRITE: begin
        mem_write_enable = 1'b1;
        mem_write_data   = merge_data;
      end
      default: mem_write_enable = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a negedge monitor pops and compares data, error flag and response cycle.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_write_enable;
  logic [31:0] mem_adress;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];
  logic        mem_init;
  int          wr_cnt = 0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .mem_write_enable (mem_write_enable),
    .mem_adress       (mem_adress),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_adress[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h8091A2B3;
    end else if (mem_write_enable) begin
      mem[mem_adress[7:2]] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, ".rdata"}, rsp_rdata, mon_e.rdata);
        check({mon_e.name, ".error"}, {31'd0, rsp_error}, {31'd0, mon_e.err});
        check({mon_e.name, ".cycle"}, 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.timeout: got %0d pending responses expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_req(input string name, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat,
                         input int exp_writes);
    int wr0;
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    e.name = name; e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat;
    sb.push_back(e);
    wr0 = wr_cnt;
    req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0; req_size = 2'd3; req_write = ~wr;
    check({name, ".busy"}, {31'd0, req_ready}, 32'd0);
    wait_drain(name);
    check({name, ".writes"}, 32'(wr_cnt - wr0), 32'(exp_writes));
  endtask

  initial begin
    int wr0;
    int c0;
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #1;
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_error", {31'd0, rsp_error}, 32'd0);
    check("rst.mem_we", {31'd0, mem_write_enable}, 32'd0);
    check("rst.mem_adress", mem_adress, 32'd0);
    check("rst.mem_wdata", mem_write_data, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    reset = 1'b0;

    // Loads from the preloaded word 0x8091A2B3 at 0x10.
    run_req("ld_w",     1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8091A2B3, 1'b0, 2, 0);
    run_req("ld_w_sgn", 1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 32'h8091A2B3, 1'b0, 2, 0);
    run_req("ld_b_s1",  1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'hFFFFFF91, 1'b0, 2, 0);
    run_req("ld_b_u1",  1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h00000091, 1'b0, 2, 0);
    run_req("ld_b_s3",  1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'hFFFFFFB3, 1'b0, 2, 0);
    run_req("ld_b_u0",  1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h00000080, 1'b0, 2, 0);
    run_req("ld_h_s0",  1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'hFFFF8091, 1'b0, 2, 0);
    run_req("ld_h_u2",  1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000A2B3, 1'b0, 2, 0);
    run_req("ld_h_s2",  1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'hFFFFA2B3, 1'b0, 2, 0);

    // Error cases: one cycle latency, no memory access.
    run_req("err_h13",  1'b0, 2'd1, 1'b0, 32'h13,  32'h0, 32'h0, 1'b1, 1, 0);
    run_req("err_w0e",  1'b0, 2'd2, 1'b0, 32'h0E,  32'h0, 32'h0, 1'b1, 1, 0);
    run_req("err_sz3",  1'b0, 2'd3, 1'b0, 32'h10,  32'h0, 32'h0, 1'b1, 1, 0);
    run_req("err_b100", 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0);
    run_req("err_st_b", 1'b1, 2'd0, 1'b0, 32'h100, 32'hFF, 32'h0, 1'b1, 1, 0);
    run_req("err_st_w", 1'b1, 2'd2, 1'b0, 32'h12,  32'h11223344, 32'h0, 1'b1, 1, 0);
    check("err.mem4", mem[4], 32'h8091A2B3);

    // Reset during RMW_READ of a byte store to 0x10 abandons the write.
    wr0 = wr_cnt;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rmw_rst.pre_adress", mem_adress, 32'h10);
    #1;
    reset = 1'b1;
    #1;
    check("rmw_rst.mem_adress", mem_adress, 32'd0);
    check("rmw_rst.req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rmw_rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    check("rmw_rst.mem4", mem[4], 32'h8091A2B3);
    check("rmw_rst.writes", 32'(wr_cnt - wr0), 32'd0);

    // Reset while a word store is driving the port drops the write enable at once.
    wr0 = wr_cnt;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd2; req_addr = 32'h14; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("stw_rst.we_before", {31'd0, mem_write_enable}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("stw_rst.we_after", {31'd0, mem_write_enable}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("stw_rst.mem5", mem[5], 32'd0);
    check("stw_rst.writes", 32'(wr_cnt - wr0), 32'd0);

    // Sub-word stores by read-modify-write, then a word store.
    run_req("st_b12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h0000005A, 32'h0, 1'b0, 3, 1);
    check("st_b12.mem4", mem[4], 32'h80915AB3);
    run_req("st_h10", 1'b1, 2'd1, 1'b1, 32'h10, 32'hABCD1234, 32'h0, 1'b0, 3, 1);
    check("st_h10.mem4", mem[4], 32'h12345AB3);
    run_req("st_b13", 1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFFC6, 32'h0, 1'b0, 3, 1);
    check("st_b13.mem4", mem[4], 32'h12345AC6);
    run_req("ld_after", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h12345AC6, 1'b0, 2, 0);

    // Back-to-back with req_valid held: word store then word load at 0x20.
    wr0 = wr_cnt;
    @(negedge clk);
    c0 = cyc;
    sb.push_back('{name: "b2b_st", rdata: 32'h0, err: 1'b0, cyc: c0 + 2});
    sb.push_back('{name: "b2b_ld", rdata: 32'hDEADBEEF, err: 1'b0, cyc: c0 + 5});
    req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_write = 1'b0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_drain("b2b");
    check("b2b.mem8", mem[8], 32'hDEADBEEF);
    check("b2b.writes", 32'(wr_cnt - wr0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish after 200000 time units expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
